// File: rtl/flag_condition_unit.sv
// -----------------------------------------------------------------------------
// flag_condition_unit
//
// Purpose:
//   Holds the ALU status word (N,Z,V,C) and evaluates 4-bit branch condition
//   codes against it. Each accepted request produces {taken, flags} in a
//   small result FIFO that branch/predication control drains.
//
// Handshakes (both sides):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   The producer holds valid and its payload until the transfer occurs; the
//   receiver may raise or lower ready on any cycle. Payload is stable while
//   valid=1 and ready=0.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   flags_n_z_v_c  in   [3:0] ALU flags: bit3=N, bit2=Z, bit1=V, bit0=C
//   flags_we       in   load flags_n_z_v_c into the status register
//   req_valid      in   condition request valid
//   req_cond       in   [3:0] condition code to evaluate
//   req_ready      out  request can be accepted (FIFO not full)
//   resp_valid     out  FIFO head valid
//   resp_taken     out  condition result at FIFO head
//   resp_flags     out  [3:0] flag snapshot used for the head result
//   resp_ready     in   consumer accepts the head
//   flags_q        out  [3:0] current status register
//   eval_count     out  [CNT_W-1:0] accepted-request count, wraps
// -----------------------------------------------------------------------------
module flag_condition_unit #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       flags_n_z_v_c,
   input  logic             flags_we,
   input  logic             req_valid,
   input  logic [3:0]       req_cond,
   output logic             req_ready,
   output logic             resp_valid,
   output logic             resp_taken,
   output logic [3:0]       resp_flags,
   input  logic             resp_ready,
   output logic [3:0]       flags_q,
   output logic [CNT_W-1:0] eval_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

   logic [3:0]       r_flags;
   logic [CNT_W-1:0] r_eval_count;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             r_mem_taken [DEPTH];
   logic [3:0]       r_mem_flags [DEPTH];

   logic [3:0] w_eff_flags;
   logic       w_taken;
   logic       w_push;
   logic       w_pop;

   // Full table evaluation of one condition code against one flag word.
   function automatic logic f_eval(input logic [3:0] cond, input logic [3:0] fl);
      logic n, z, v, c;
      n = fl[3];
      z = fl[2];
      v = fl[1];
      c = fl[0];
      case (cond)
         4'd0:    f_eval = z;
         4'd1:    f_eval = !z;
         4'd2:    f_eval = c;
         4'd3:    f_eval = !c;
         4'd4:    f_eval = n;
         4'd5:    f_eval = !n;
         4'd6:    f_eval = v;
         4'd7:    f_eval = !v;
         4'd8:    f_eval = c && !z;
         4'd9:    f_eval = !c || z;
         4'd10:   f_eval = (n == v);
         4'd11:   f_eval = (n != v);
         4'd12:   f_eval = !z && (n == v);
         4'd13:   f_eval = z || (n != v);
         4'd14:   f_eval = 1'b1;
         default: f_eval = 1'b0;
      endcase
   endfunction

   // A request accepted in the same cycle as a flag write sees the new flags.
   assign w_eff_flags = flags_we ? flags_n_z_v_c : r_flags;
   assign w_taken     = f_eval(req_cond, w_eff_flags);

   // No full bypass: a full FIFO refuses requests even if the head pops now.
   assign req_ready  = (r_count < DEPTH_C);
   assign resp_valid = (r_count != '0);
   assign w_push     = req_valid && req_ready;
   assign w_pop      = resp_valid && resp_ready;

   // Head outputs are forced to zero when empty so reset and idle look clean.
   assign resp_taken = resp_valid && r_mem_taken[r_rd_ptr];
   assign resp_flags = resp_valid ? r_mem_flags[r_rd_ptr] : 4'b0000;

   assign flags_q    = r_flags;
   assign eval_count = r_eval_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flags <= 4'b0000;
      end else if (flags_we) begin
         r_flags <= flags_n_z_v_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_eval_count <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_taken[i] <= 1'b0;
            r_mem_flags[i] <= 4'b0000;
         end
      end else begin
         if (w_push) begin
            r_mem_taken[r_wr_ptr] <= w_taken;
            r_mem_flags[r_wr_ptr] <= w_eff_flags;
            r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
            r_eval_count          <= r_eval_count + CNT_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_flag_condition_unit.sv
// -----------------------------------------------------------------------------
// tb_flag_condition_unit
//
// Directed bench for flag_condition_unit. Inputs change 1 time unit after a
// rising edge; outputs are sampled on the falling edge. Every accepted
// request pushes its expected {taken, flags} into exp_q; a monitor pops and
// compares on each falling edge where resp_valid && resp_ready.
// -----------------------------------------------------------------------------
module tb_flag_condition_unit;

   localparam int DEPTH = 2;
   localparam int CNT_W = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]       flags_n_z_v_c = 4'b0000;
   logic             flags_we = 1'b0;
   logic             req_valid = 1'b0;
   logic [3:0]       req_cond = 4'd0;
   logic             req_ready;
   logic             resp_valid;
   logic             resp_taken;
   logic [3:0]       resp_flags;
   logic             resp_ready = 1'b0;
   logic [3:0]       flags_q;
   logic [CNT_W-1:0] eval_count;

   flag_condition_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flags_n_z_v_c (flags_n_z_v_c),
      .flags_we      (flags_we),
      .req_valid     (req_valid),
      .req_cond      (req_cond),
      .req_ready     (req_ready),
      .resp_valid    (resp_valid),
      .resp_taken    (resp_taken),
      .resp_flags    (resp_flags),
      .resp_ready    (resp_ready),
      .flags_q       (flags_q),
      .eval_count    (eval_count)
   );

   // ---------------- scoreboard state ----------------
   logic [4:0]       exp_q[$];
   logic [CNT_W-1:0] exp_eval = '0;
   int               n_vec = 0;
   int               n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: conditions come in complementary pairs; the even code
   // is the base predicate and the odd code is its inverse.
   function automatic logic model_taken(input logic [3:0] f, input logic [3:0] cond);
      logic [7:0] base;
      base[0] = f[2];                       // EQ
      base[1] = f[0];                       // CS
      base[2] = f[3];                       // MI
      base[3] = f[1];                       // VS
      base[4] = f[0] & ~f[2];               // HI
      base[5] = ~(f[3] ^ f[1]);             // GE
      base[6] = ~f[2] & ~(f[3] ^ f[1]);     // GT
      base[7] = 1'b1;                       // AL
      return base[cond[3:1]] ^ cond[0];
   endfunction

   // ---------------- monitor ----------------
   initial begin
      logic [4:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL resp_unexpected: got %0h expected none at %0t",
                        {resp_taken, resp_flags}, $time);
            end else begin
               e = exp_q.pop_front();
               check("resp_head", {27'd0, resp_taken, resp_flags}, {27'd0, e});
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // All tasks start and end at posedge + 1.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_flags(input logic [3:0] f);
      flags_we      = 1'b1;
      flags_n_z_v_c = f;
      step();
      flags_we = 1'b0;
      check("flags_q_load", {28'd0, flags_q}, {28'd0, f});
   endtask

   task automatic send(input logic [3:0] cond, input logic we, input logic [3:0] f,
                       input logic exp_t, input logic [3:0] exp_f);
      bit accepted = 0;
      int waited = 0;
      req_valid     = 1'b1;
      req_cond      = cond;
      flags_we      = we;
      flags_n_z_v_c = f;
      while (!accepted && waited < 20) begin
         @(negedge clk);
         if (req_ready) accepted = 1;
         @(posedge clk);
         #1;
         waited++;
      end
      req_valid = 1'b0;
      flags_we  = 1'b0;
      if (accepted) begin
         exp_q.push_back({exp_t, exp_f});
         exp_eval = exp_eval + 1'b1;
      end else begin
         n_vec++;
         n_err++;
         $display("FAIL req_timeout: got req_ready=0 expected accept, cond %0d", cond);
      end
   endtask

   task automatic drain();
      int waited = 0;
      while (exp_q.size() != 0 && waited < 50) begin
         step();
         waited++;
      end
      check("drain_empty", exp_q.size(), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Reset values
      #3;
      check("rst_resp_valid", {31'd0, resp_valid}, 0);
      check("rst_req_ready",  {31'd0, req_ready},  1);
      check("rst_flags_q",    {28'd0, flags_q},    0);
      check("rst_eval_count", {24'd0, eval_count}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Basic evaluation, one-cycle latency
      resp_ready = 1'b1;
      load_flags(4'b0100);
      send(4'd0, 1'b0, 4'b0000, 1'b1, 4'b0100);
      check("latency_valid", {31'd0, resp_valid}, 1);
      check("eq_taken",      {31'd0, resp_taken}, 1);
      check("eq_flags",      {28'd0, resp_flags}, 4'b0100);
      send(4'd1, 1'b0, 4'b0000, 1'b0, 4'b0100);
      check("ne_taken",      {31'd0, resp_taken}, 0);
      drain();

      // Forwarding: same-cycle flag write seen by the request
      load_flags(4'b0000);
      send(4'd11, 1'b1, 4'b1000, 1'b1, 4'b1000);
      check("fwd_flags_q", {28'd0, flags_q}, 4'b1000);
      drain();

      // Full / backpressure: no bypass while full
      resp_ready = 1'b0;
      send(4'd14, 1'b0, 4'b0000, 1'b1, 4'b1000);
      send(4'd15, 1'b0, 4'b0000, 1'b0, 4'b1000);
      req_valid = 1'b1;
      req_cond  = 4'd14;
      @(negedge clk);
      check("full_req_ready", {31'd0, req_ready}, 0);
      @(posedge clk);
      #1;
      resp_ready = 1'b1;
      @(negedge clk);
      check("no_bypass_ready", {31'd0, req_ready}, 0);
      @(posedge clk);
      #1;
      send(4'd14, 1'b0, 4'b0000, 1'b1, 4'b1000);
      drain();

      // Simultaneous push/pop with one entry queued
      resp_ready = 1'b0;
      send(4'd3, 1'b1, 4'b0001, 1'b0, 4'b0001);
      resp_ready = 1'b1;
      send(4'd2, 1'b0, 4'b0000, 1'b1, 4'b0001);
      check("pushpop_valid", {31'd0, resp_valid}, 1);
      check("pushpop_ready", {31'd0, req_ready},  1);
      check("pushpop_head",  {31'd0, resp_taken}, 1);
      drain();

      // Mid-operation reset with two queued results
      resp_ready = 1'b0;
      send(4'd14, 1'b1, 4'b1111, 1'b1, 4'b1111);
      send(4'd14, 1'b0, 4'b0000, 1'b1, 4'b1111);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_resp_valid", {31'd0, resp_valid}, 0);
      check("mid_rst_resp_taken", {31'd0, resp_taken}, 0);
      check("mid_rst_resp_flags", {28'd0, resp_flags}, 0);
      check("mid_rst_req_ready",  {31'd0, req_ready},  1);
      check("mid_rst_eval_count", {24'd0, eval_count}, 0);
      check("mid_rst_flags_q",    {28'd0, flags_q},    0);
      exp_q.delete();
      exp_eval = '0;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("post_rst_resp_valid", {31'd0, resp_valid}, 0);

      // Full table sweep: first code of each row forwards, the rest use flags_q
      resp_ready = 1'b1;
      for (int f = 0; f < 16; f++) begin
         for (int c = 0; c < 16; c++) begin
            send(4'(c), (c == 0), 4'(f), model_taken(4'(f), 4'(c)), 4'(f));
         end
         check("sweep_flags_q", {28'd0, flags_q}, f);
      end
      drain();
      check("eval_wrap", {24'd0, eval_count}, 0);
      check("eval_model", {24'd0, eval_count}, {24'd0, exp_eval});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/flag_condition_unit.md
Name: flag_condition_unit

Overview:
- Consumer side of the ALU status interface: registers the 4-bit flags_n_z_v_c word produced by ALU blocks and evaluates 4-bit branch condition codes against it.
- Requests arrive over a valid/ready handshake; results leave over a valid/ready handshake, buffered in a small FIFO.
- Sits between the ALU datapath and branch/predication control in the processor.

Parameters:
- DEPTH, 2, number of result-FIFO entries (power of two, >= 2).
- CNT_W, 8, width of the wrapping evaluation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flags_n_z_v_c  in  4  ALU flags. bit3=N, bit2=Z, bit1=V, bit0=C.
- flags_we  in  1  load flags_n_z_v_c into the status register this cycle.
- req_valid  in  1  condition request valid.
- req_cond  in  4  condition code to evaluate.
- req_ready  out  1  unit can accept a request.
- resp_valid  out  1  FIFO head valid.
- resp_taken  out  1  condition result at FIFO head.
- resp_flags  out  4  flag snapshot used for the head result.
- resp_ready  in  1  consumer accepts head.
- flags_q  out  4  current status register.
- eval_count  out  CNT_W  count of accepted requests, wraps.

Behaviour:
- Reset (async assert, sync release): flags_q=0000, FIFO empty, resp_valid=0, resp_taken=0, resp_flags=0000, eval_count=0, req_ready=1.
- Reset asserted mid-operation discards all queued results immediately. No partial state survives.
- Status register: on a rising edge with flags_we=1, flags_q <= flags_n_z_v_c. Otherwise it holds.
- Flag forwarding: a request accepted in the same cycle as flags_we=1 evaluates against the incoming flags_n_z_v_c, not the old flags_q. resp_flags records that value.
- Accept condition: req_valid && req_ready at a rising edge. req_ready = (count < DEPTH). There is no same-cycle full bypass, so req_ready=0 when full even if resp_ready=1.
- On accept, {taken, flags} is pushed to the FIFO tail. eval_count increments modulo 2^CNT_W (255 -> 0).
- Latency: a request accepted at edge k into an empty FIFO gives resp_valid=1 after edge k, i.e. 1 cycle. No combinational path from req to resp.
- Dequeue condition: resp_valid && resp_ready at an edge pops the head. resp_valid/resp_taken/resp_flags stay stable while resp_valid=1 and resp_ready=0.
- Simultaneous push and pop when not full: count is unchanged and ordering is preserved. With 1 entry, the new entry becomes head after the edge.
- Pop from an empty FIFO is ignored. Push when full cannot occur because req_ready=0.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Condition table (taken):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - 10 GE: N==V
  - 11 LT: N!=V
  - 12 GT: !Z&(N==V)
  - 13 LE: Z|(N!=V)
  - 14 AL: 1
  - 15 NV: 0

Test Plan:
- Reset check: assert rst_n=0 mid-sim with 2 queued results -> outputs immediately at reset values, req_ready=1, eval_count=0.
- Basic eval: flags_we=1 with flags=0100, then next cycle req_cond=0 -> one cycle later resp_valid=1, resp_taken=1, resp_flags=0100. req_cond=1 -> taken=0.
- Forwarding: flags_q=0000, same-cycle flags_we=1 with flags=1000 and req_cond=11 (LT) -> taken=1, resp_flags=1000.
- Full/backpressure: resp_ready=0, issue 3 requests (conds 14, 15, 14) -> first 2 accepted, req_ready=0 on the third. Then raise resp_ready -> results pop in order 1, 0, then the third is accepted and gives 1.
- Full table sweep: for all 16 flag values × 16 conds with resp_ready=1 -> every resp_taken matches the table. eval_count reaches 256 mod 256 = 0.
- Simultaneous push/pop: with 1 entry queued, resp_ready=1 and req_valid=1 in the same cycle -> count stays 1 and the head becomes the new result next cycle.
